lifting_53_mac: RTL and testbench
=================================

// Module: lifting_53_mac
// PURPOSE
//  LeGall 5/3 integer lifting filter for the 2D DWT datapath. Consumes the pixel-pair
//  stream ({x[2k],x[2k+1]} plus row/column and pixel pointers) issued by the DWT control
//  logic for one row or column pass. Returns {approx s[k], detail d[k]} with the pair's
//  pointers to the control logic write port. Symmetric extension at line ends; no backpressure.
// PARAMETERS
//  WIDTH    256  max image width (and pointer range); must be >= HEIGHT, power of 2
//  HEIGHT   256  max image height
//  MIN_LEN  4    smallest legal line length (samples); i_line_len < MIN_LEN -> o_err
//  (localparam PTR_W = $clog2(WIDTH))
// PORTS
//  clk                   in   1        clock
//  rst                   in   1        reset
//  i_valid               in   1        input pair valid; accepted every cycle it is high
//  i_pair                in   16       {x[2k] [15:8], x[2k+1] [7:0]}, unsigned
//  i_pixel_pointer       in   PTR_W    2k, index of even sample within line
//  i_row_column_pointer  in   PTR_W    line index
//  i_line_len            in   PTR_W+1  samples in current line (WIDTH>>lvl or HEIGHT>>lvl)
//  o_valid               out  1        result pair valid (one-cycle pulse per pair)
//  o_pair                out  16       {s[k] [15:8], d[k]+128 [7:0]}, both clamped 0..255
//  o_pixel_pointer       out  PTR_W    2k of the emitted pair
//  o_row_column_pointer  out  PTR_W    line index of the emitted pair
//  o_err                 out  1        sticky protocol error flag
// BEHAVIOUR
//  Reset: rst synchronous, active-high; clock clk. All outputs 0, state IDLE, pending data dropped.
//  Lifting (signed, full precision internally; d 10b, s 11b):
//   d[k] = x[2k+1] - floor((x[2k]+x[2k+2])/2);  s[k] = x[2k] + floor((d[k-1]+d[k]+2)/4)
//   Extension: d[-1]=d[0]; x[2N]=x[2N-2] at line end (N=i_line_len/2) -> d[N-1]=x[2N-1]-x[2N-2].
//   floor = arithmetic shift right. Output: s clamped to 0..255; d+128 clamped to 0..255.
//   Unclamped d[k] retained for s[k+1].
//  State machine:
//   IDLE : valid & ptr==0 -> store e0,o0, ptr, row, len -> RUN (no output).
//          valid & ptr!=0 -> o_err<=1, drop.
//   RUN  : valid & ptr==prev+2 -> compute d[k-1],s[k-1] from stored pair + new e_k; emit
//          with prev pointers next cycle; store d[k-1], e_k,o_k.
//          If ptr==len-2 -> FLUSH, else stay.
//          valid & ptr==0 -> o_err<=1, discard pending line, restart as IDLE would.
//          Other ptr -> o_err<=1, drop.
//   FLUSH: always emit last pair (d[N-1],s[N-1], ptr len-2) next cycle, from stored regs.
//          Same cycle valid & ptr==0 accepted as new line's first pair -> RUN;
//          no valid -> IDLE; valid & ptr!=0 -> o_err, IDLE.
//  Latency: result for pair k emitted 1 cycle after pair k+1 accepted; last pair 1 cycle
//   after FLUSH. Back-to-back lines lose no slot (row-start produces no output).
//  Gaps in i_valid anywhere are legal; outputs identical to gapless stream.
//  Output count per line = N. o_valid deasserts when nothing emitted.
//  o_pair/pointers hold last value.
//  i_line_len sampled at ptr==0 only. len odd or < MIN_LEN -> o_err, line dropped.
//  o_err cleared only by rst.
// TESTING
//  1 len4 {10,20},{30,40} -> {10,128}@ptr0, then {33,138}@ptr2 on consecutive cycles
//  2 len4 {0,255},{0,255} -> {128,255},{128,255}; {255,0},{255,0} -> {128,0},{128,0}
//  3 row0 len4 last pair then row1 ptr0 next cycle -> row0 flush and row1 flow, 4 outputs, row ids correct
//  4 len8 ramp 0..7 with random i_valid gaps -> bitwise equal to gapless run, 4 outputs
//  5 rst after 2nd pair of len8 line -> o_valid 0, no flush; next line correct, o_err 0
//  6 first pair ptr4 in IDLE -> o_err=1 sticky, no output; ptr skip 0->4 in RUN -> o_err=1

Source files
------------

// File: rtl/lifting_53_mac.sv
// LeGall 5/3 integer lifting stage for the 2D DWT datapath.
// Takes one even/odd sample pair per accepted cycle along a row or column and
// returns the matching {approx, detail} pair one pair later. Symmetric extension
// is applied at both line ends. The final pair of a line is flushed from the
// stored registers with no further input.
//
// Handshake: there is no ready. A pair is consumed on every cycle i_valid is high.
// o_valid is a one-cycle pulse per emitted pair. o_pair and the pointers hold
// their last value while o_valid is low.
module lifting_53_mac #(
  parameter int WIDTH   = 256,
  parameter int HEIGHT  = 256,
  parameter int MIN_LEN = 4,
  localparam int PTR_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [15:0]      i_pair,
  input  logic [PTR_W-1:0] i_pixel_pointer,
  input  logic [PTR_W-1:0] i_row_column_pointer,
  input  logic [PTR_W:0]   i_line_len,
  output logic             o_valid,
  output logic [15:0]      o_pair,
  output logic [PTR_W-1:0] o_pixel_pointer,
  output logic [PTR_W-1:0] o_row_column_pointer,
  output logic             o_err,
  output logic [1:0]       o_dbg_state
);

  localparam int LEN_W = PTR_W + 1;

  // A column pass reuses the row pointer range, so HEIGHT must fit inside WIDTH.
  if (WIDTH < HEIGHT) begin : g_cfg_check
    $error("lifting_53_mac: WIDTH must be >= HEIGHT");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         e_q;        // stored even sample x[2k]
  logic [7:0]         o_q;        // stored odd sample x[2k+1]
  logic signed [11:0] d_prev_q;   // unclamped d of the previous pair
  logic               first_q;    // stored pair is pair 0, so d[-1] mirrors d[0]
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   row_q;
  logic [LEN_W-1:0]   len_q;

  logic               valid_q;
  logic [15:0]        pair_q;
  logic [PTR_W-1:0]   out_ptr_q;
  logic [PTR_W-1:0]   out_row_q;
  logic               err_q;

  // Saturate a signed intermediate into the unsigned 8-bit output range.
  function automatic logic [7:0] clamp8(input logic signed [11:0] v);
    if (v < 0) begin
      clamp8 = 8'd0;
    end else if (v > 12'sd255) begin
      clamp8 = 8'd255;
    end else begin
      clamp8 = v[7:0];
    end
  endfunction

  logic signed [11:0] e_cur, o_cur, e_nxt, sum_e, d_new, d_left, s_acc, s_new, d_off;
  logic [15:0]        res_pair;
  logic               start_ok;
  logic               ptr_next;
  logic               ptr_last;

  // Lifting arithmetic for the stored pair. The right neighbour comes from the
  // incoming pair, or mirrors the stored even sample when flushing the line end.
  always_comb begin
    e_cur    = $signed({4'd0, e_q});
    o_cur    = $signed({4'd0, o_q});
    e_nxt    = (state_q == S_FLUSH) ? e_cur : $signed({4'd0, i_pair[15:8]});
    sum_e    = e_cur + e_nxt;
    d_new    = o_cur - (sum_e >>> 1);
    d_left   = first_q ? d_new : d_prev_q;
    s_acc    = d_left + d_new + 12'sd2;
    s_new    = e_cur + (s_acc >>> 2);
    d_off    = d_new + 12'sd128;
    res_pair = {clamp8(s_new), clamp8(d_off)};
    start_ok = (i_pixel_pointer == '0) && (i_line_len >= LEN_W'(MIN_LEN)) && !i_line_len[0];
    ptr_next = (i_pixel_pointer == ptr_q + PTR_W'(2));
    ptr_last = ({1'b0, i_pixel_pointer} == len_q - LEN_W'(2));
  end

  // Line sequencer: stores the newest pair, emits the previous one, and flushes
  // the last pair of a line while already accepting the next line's first pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      e_q       <= '0;
      o_q       <= '0;
      d_prev_q  <= '0;
      first_q   <= 1'b0;
      ptr_q     <= '0;
      row_q     <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      pair_q    <= '0;
      out_ptr_q <= '0;
      out_row_q <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            if (start_ok) begin
              e_q     <= i_pair[15:8];
              o_q     <= i_pair[7:0];
              ptr_q   <= '0;
              row_q   <= i_row_column_pointer;
              len_q   <= i_line_len;
              first_q <= 1'b1;
              state_q <= S_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_valid) begin
            if (i_pixel_pointer == '0) begin
              // A restart abandons the pending line without emitting it.
              err_q <= 1'b1;
              if (start_ok) begin
                e_q     <= i_pair[15:8];
                o_q     <= i_pair[7:0];
                ptr_q   <= '0;
                row_q   <= i_row_column_pointer;
                len_q   <= i_line_len;
                first_q <= 1'b1;
                state_q <= S_RUN;
              end else begin
                state_q <= S_IDLE;
              end
            end else if (ptr_next) begin
              valid_q   <= 1'b1;
              pair_q    <= res_pair;
              out_ptr_q <= ptr_q;
              out_row_q <= row_q;
              d_prev_q  <= d_new;
              first_q   <= 1'b0;
              e_q       <= i_pair[15:8];
              o_q       <= i_pair[7:0];
              ptr_q     <= i_pixel_pointer;
              if (ptr_last) begin
                state_q <= S_FLUSH;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          valid_q   <= 1'b1;
          pair_q    <= res_pair;
          out_ptr_q <= ptr_q;
          out_row_q <= row_q;
          if (i_valid && start_ok) begin
            e_q     <= i_pair[15:8];
            o_q     <= i_pair[7:0];
            ptr_q   <= '0;
            row_q   <= i_row_column_pointer;
            len_q   <= i_line_len;
            first_q <= 1'b1;
            state_q <= S_RUN;
          end else begin
            if (i_valid) begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_valid              = valid_q;
  assign o_pair               = pair_q;
  assign o_pixel_pointer      = out_ptr_q;
  assign o_row_column_pointer = out_row_q;
  assign o_err                = err_q;
  assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_lifting_53_mac.sv
// Bench for lifting_53_mac: directed lines checked against a 5/3 lifting model.
module tb_lifting_53_mac;
  localparam int PTR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic [15:0]      i_pair;
  logic [PTR_W-1:0] i_pixel_pointer;
  logic [PTR_W-1:0] i_row_column_pointer;
  logic [PTR_W:0]   i_line_len;
  logic             o_valid;
  logic [15:0]      o_pair;
  logic [PTR_W-1:0] o_pixel_pointer;
  logic [PTR_W-1:0] o_row_column_pointer;
  logic             o_err;
  logic [1:0]       o_dbg_state;

  lifting_53_mac #(.WIDTH(256), .HEIGHT(256), .MIN_LEN(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_valid              (i_valid),
    .i_pair               (i_pair),
    .i_pixel_pointer      (i_pixel_pointer),
    .i_row_column_pointer (i_row_column_pointer),
    .i_line_len           (i_line_len),
    .o_valid              (o_valid),
    .o_pair               (o_pair),
    .o_pixel_pointer      (o_pixel_pointer),
    .o_row_column_pointer (o_row_column_pointer),
    .o_err                (o_err),
    .o_dbg_state          (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];      // {row, ptr, s, d+128}
  int          out_cyc_q[$];
  int          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none",
                 {o_row_column_pointer, o_pixel_pointer, o_pair});
      end else begin
        chk("out_pair", {o_row_column_pointer, o_pixel_pointer, o_pair}, exp_q.pop_front());
      end
    end
  end

  // ---------------- model ----------------
  logic [7:0] line_x [0:255];

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic logic [7:0] clamp(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic int model_d(input int len, input int k);
    int n = len / 2;
    int xl = int'(line_x[2*k]);
    int xr = (k == n - 1) ? xl : int'(line_x[2*k+2]);
    return int'(line_x[2*k+1]) - floor_div(xl + xr, 2);
  endfunction

  function automatic logic [15:0] model_pair(input int len, input int k);
    int dk = model_d(len, k);
    int dl = (k == 0) ? dk : model_d(len, k - 1);
    int s  = int'(line_x[2*k]) + floor_div(dl + dk + 2, 4);
    return {clamp(s), clamp(dk + 128)};
  endfunction

  task automatic push_line(input int row, input int len);
    for (int k = 0; k < len / 2; k++)
      exp_q.push_back({8'(row), 8'(2*k), model_pair(len, k)});
  endtask

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int row, input int ptr, input int len, input logic [7:0] e, input logic [7:0] o);
    i_valid              = 1'b1;
    i_pair               = {e, o};
    i_pixel_pointer      = 8'(ptr);
    i_row_column_pointer = 8'(row);
    i_line_len           = 9'(len);
    @(posedge clk);
    #1;
    last_acc = cyc;
    i_valid  = 1'b0;
  endtask

  task automatic send_line(input int row, input int len, input bit gaps);
    for (int k = 0; k < len / 2; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(row, 2*k, len, line_x[2*k], line_x[2*k+1]);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle(4);
  endtask

  task automatic set4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    line_x[0] = a; line_x[1] = b; line_x[2] = c; line_x[3] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  int acc1;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; i_valid = 1'b0; i_pair = '0;
    i_pixel_pointer = '0; i_row_column_pointer = '0; i_line_len = '0;
    idle(3);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pair",  32'(o_pair), 32'd0);
    chk("rst_ptrs",  {16'd0, o_row_column_pointer, o_pixel_pointer}, 32'd0);
    chk("rst_err",   32'(o_err), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: {10,20},{30,40}
    set4(8'd10, 8'd20, 8'd30, 8'd40);
    chk("model_t1_k0", 32'(model_pair(4, 0)), {16'd0, 8'd10, 8'd128});
    chk("model_t1_k1", 32'(model_pair(4, 1)), {16'd0, 8'd33, 8'd138});
    exp_q.push_back({8'd0, 8'd0, 8'd10, 8'd128});
    exp_q.push_back({8'd0, 8'd2, 8'd33, 8'd138});
    out_cyc_q.delete();
    send_line(0, 4, 1'b0);
    acc1 = last_acc;
    drain("t1");
    chk("t1_count", 32'(out_cyc_q.size()), 32'd2);
    chk("t1_latency", 32'(out_cyc_q[0]), 32'(acc1));
    chk("t1_consec", 32'(out_cyc_q[1]), 32'(out_cyc_q[0] + 1));

    // 2: clamping at both extremes
    set4(8'd0, 8'd255, 8'd0, 8'd255);
    chk("model_t2a_k0", 32'(model_pair(4, 0)), {16'd0, 8'd128, 8'd255});
    chk("model_t2a_k1", 32'(model_pair(4, 1)), {16'd0, 8'd128, 8'd255});
    exp_q.push_back({8'd1, 8'd0, 8'd128, 8'd255});
    exp_q.push_back({8'd1, 8'd2, 8'd128, 8'd255});
    send_line(1, 4, 1'b0);
    drain("t2a");
    set4(8'd255, 8'd0, 8'd255, 8'd0);
    chk("model_t2b_k0", 32'(model_pair(4, 0)), {16'd0, 8'd128, 8'd0});
    chk("model_t2b_k1", 32'(model_pair(4, 1)), {16'd0, 8'd128, 8'd0});
    exp_q.push_back({8'd2, 8'd0, 8'd128, 8'd0});
    exp_q.push_back({8'd2, 8'd2, 8'd128, 8'd0});
    send_line(2, 4, 1'b0);
    drain("t2b");

    // 3: back-to-back lines, row 0 then row 1
    out_cyc_q.delete();
    set4(8'd5, 8'd9, 8'd200, 8'd3);
    push_line(0, 4);
    send_line(0, 4, 1'b0);
    set4(8'd50, 8'd60, 8'd70, 8'd80);
    push_line(1, 4);
    send_line(1, 4, 1'b0);
    drain("t3");
    chk("t3_count", 32'(out_cyc_q.size()), 32'd4);
    chk("t3_noslot_lost", 32'(out_cyc_q[3]), 32'(out_cyc_q[0] + 3));

    // 4: len8 ramp, gapless then gapped; longer random gapped line
    for (int i = 0; i < 8; i++) line_x[i] = 8'(i);
    chk("model_ramp_k0", 32'(model_pair(8, 0)), {16'd0, 8'd0, 8'd128});
    chk("model_ramp_k3", 32'(model_pair(8, 3)), {16'd0, 8'd6, 8'd129});
    push_line(4, 8);
    send_line(4, 8, 1'b0);
    drain("t4_gapless");
    out_cyc_q.delete();
    push_line(4, 8);
    send_line(4, 8, 1'b1);
    drain("t4_gapped");
    chk("t4_count", 32'(out_cyc_q.size()), 32'd4);
    for (int i = 0; i < 16; i++) line_x[i] = 8'($urandom_range(0, 255));
    push_line(7, 16);
    send_line(7, 16, 1'b1);
    drain("t4_rand16");

    // Full-width line
    for (int i = 0; i < 256; i++) line_x[i] = 8'($urandom_range(0, 255));
    out_cyc_q.delete();
    push_line(255, 256);
    send_line(255, 256, 1'b0);
    drain("t_full");
    chk("full_count", 32'(out_cyc_q.size()), 32'd128);

    // 5: reset mid-line
    for (int i = 0; i < 8; i++) line_x[i] = 8'($urandom_range(0, 255));
    exp_q.push_back({8'd3, 8'd0, model_pair(8, 0)});
    send(3, 0, 8, line_x[0], line_x[1]);
    send(3, 2, 8, line_x[2], line_x[3]);
    rst = 1'b1;
    idle(1);
    chk("t5_rst_valid", 32'(o_valid), 32'd0);
    chk("t5_rst_pair", 32'(o_pair), 32'd0);
    rst = 1'b0;
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle(6);
    push_line(3, 8);
    send_line(3, 8, 1'b0);
    drain("t5_after");
    chk("t5_err", 32'(o_err), 32'd0);

    // 6: protocol errors
    do_reset();
    out_cyc_q.delete();
    send(0, 4, 8, 8'd1, 8'd2);
    chk("t6_idle_err", 32'(o_err), 32'd1);
    idle(5);
    chk("t6_sticky", 32'(o_err), 32'd1);
    chk("t6_no_output", 32'(out_cyc_q.size()), 32'd0);
    set4(8'd10, 8'd20, 8'd30, 8'd40);
    exp_q.push_back({8'd6, 8'd0, 8'd10, 8'd128});
    exp_q.push_back({8'd6, 8'd2, 8'd33, 8'd138});
    send_line(6, 4, 1'b0);
    drain("t6_good");
    chk("t6_sticky2", 32'(o_err), 32'd1);
    do_reset();
    chk("t6_rst_clear", 32'(o_err), 32'd0);
    send(0, 0, 8, 8'd1, 8'd2);
    chk("t6_run_ok", 32'(o_err), 32'd0);
    send(0, 4, 8, 8'd3, 8'd4);
    chk("t6_skip_err", 32'(o_err), 32'd1);
    do_reset();
    out_cyc_q.delete();
    send(0, 0, 5, 8'd1, 8'd2);
    chk("t6_odd_len", 32'(o_err), 32'd1);
    do_reset();
    send(0, 0, 2, 8'd1, 8'd2);
    chk("t6_short_len", 32'(o_err), 32'd1);
    idle(6);
    chk("t6_len_no_output", 32'(out_cyc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
